neuron_argmax: RTL and testbench
================================

Name: neuron_argmax

Overview:
- Stage directly downstream of the dot-product engine; consumes its VAL_SIZE-bit partial dot-product values.
- Accumulates CHUNKS consecutive partials into one neuron score, for NEURONS neurons in index order.
- Tracks the running maximum and emits the winning class index once per image.
- Feeds the classification result/readout logic.

Parameters:
NEURONS, 10, neurons (classes) per image
CHUNKS, 4, partial values summed per neuron score
VAL_SIZE, 26, width of incoming signed fixed-point partial value
ACC_SIZE, 28, width of signed score accumulator (>= VAL_SIZE)
IDX_SIZE, 4, width of class index (must hold NEURONS-1)

Ports:
clk  input  1  clock, all state on rising edge
GlobalReset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  one-cycle pulse: begin new image
value  input  VAL_SIZE  signed two's-complement partial sum from dot-product engine
value_valid  input  1  value is valid this cycle
busy  output  1  image in progress
class_out  output  IDX_SIZE  winning neuron index, held until next start
class_valid  output  1  one-cycle pulse, class_out updated

Behaviour:
- Reset (GlobalReset=0, async): state IDLE; busy=0, class_out=0, class_valid=0; accumulator, chunk count, neuron count, running max and max index cleared.
- States: IDLE, ACCUM, DONE.
- IDLE: value_valid ignored. start=1 -> ACCUM; clear accumulator, chunk count, neuron count; running max = most negative ACC_SIZE value; max index = 0.
- ACCUM: busy=1. Each value_valid edge adds sign-extended value to accumulator and increments chunk count.
- Accumulator saturation: result clamps to +(2^(ACC_SIZE-1)-1) or -2^(ACC_SIZE-1); no wrap.
- On the CHUNKS-th valid of a neuron:
  - Finished score (acc + value, saturated) is compared in the same cycle against running max.
  - Update running max and index only on strictly greater score; ties keep the lower index.
  - Accumulator and chunk count reset to 0; neuron count increments.
- Last neuron: when neuron count reaches NEURONS-1 and its final chunk is accepted -> DONE.
- DONE (exactly one cycle): class_out <= max index; class_valid=1; busy=0; next state IDLE.
  - Latency: class_valid is high in the cycle after the edge that accepted the final partial.
- start in ACCUM: abort the current image and restart as from IDLE; no class_valid for the aborted image.
- start in DONE: class_valid still pulses for the completed image; the block then enters ACCUM, not IDLE.
- value_valid deasserted mid-image: state held indefinitely; no timeout.
- Reset asserted mid-image: immediate return to reset values; partial results discarded; class_out=0.
- Signed compare over full ACC_SIZE.

Optional Feature:
- Macro: NEURON_ARGMAX_SCORE_OUT_EN.
- Defined:
  - Adds output max_score (ACC_SIZE), the winning saturated score.
  - Registered together with class_out; held until the next class_valid; reset 0.
- Undefined:
  - Port and its register are absent.
  - Running-max storage stays internal; all other behaviour identical.

Test Plan:
1. Reset then start; per neuron n feed chunks {n,n,n,n}, except neuron 7 fed {100,0,0,0}; 40 consecutive valids -> class_valid pulse 1 cycle after 40th valid, class_out=7, busy low same cycle.
2. Neurons 2 and 5 score 50, all others 10 -> class_out=2 (tie keeps lower index).
3. All scores negative: neuron n = -(n+1)*8, neuron 4 = -3 -> class_out=4.
4. Neuron 0 fed four values of +2^25-1 (ACC_SIZE=28) -> no wrap, score = 4*(2^25-1) fits; with ACC_SIZE=VAL_SIZE=26 -> saturates to 2^25-1, class_out=0. With NEURON_ARGMAX_SCORE_OUT_EN, max_score shows the exact value.
5. After 17 valids assert start again, then run a full image with winner 3 -> exactly one class_valid, class_out=3.
6. GlobalReset pulsed low after 25 valids -> busy=0 and class_out=0 immediately (async); value_valid in IDLE ignored; the next full image gives the correct result.

Source files
------------

// File: rtl/neuron_argmax_if.sv
// Handshake bundle between the dot-product engine, the argmax stage and the readout logic.
// Optional max_score signal present when NEURON_ARGMAX_SCORE_OUT_EN is defined.
interface neuron_argmax_if #(
  parameter int unsigned VAL_SIZE = 26,
`ifdef NEURON_ARGMAX_SCORE_OUT_EN
  parameter int unsigned ACC_SIZE = 28,
`endif
  parameter int unsigned IDX_SIZE = 4
) ();
  logic                start;
  logic [VAL_SIZE-1:0] value;
  logic                value_valid;
  logic                busy;
  logic [IDX_SIZE-1:0] class_out;
  logic                class_valid;
`ifdef NEURON_ARGMAX_SCORE_OUT_EN
  logic [ACC_SIZE-1:0] max_score;

  modport master (output start, value, value_valid,
                  input  busy, class_out, class_valid, max_score);
  modport slave  (input  start, value, value_valid,
                  output busy, class_out, class_valid, max_score);
`else
  modport master (output start, value, value_valid,
                  input  busy, class_out, class_valid);
  modport slave  (input  start, value, value_valid,
                  output busy, class_out, class_valid);
`endif
endinterface

// File: rtl/neuron_argmax.sv
// Sums CHUNKS partials per neuron with saturation and reports the argmax class once per image.
// Define NEURON_ARGMAX_SCORE_OUT_EN to also export the winning score on max_score.
module neuron_argmax #(
  parameter int unsigned NEURONS  = 10,
  parameter int unsigned CHUNKS   = 4,
  parameter int unsigned VAL_SIZE = 26,
  parameter int unsigned ACC_SIZE = 28,
  parameter int unsigned IDX_SIZE = 4
) (
  input logic            clk,
  input logic            GlobalReset,
  neuron_argmax_if.slave bus
);

  localparam int unsigned CntW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic signed [ACC_SIZE-1:0] AccMin = {1'b1, {(ACC_SIZE-1){1'b0}}};
  localparam logic signed [ACC_SIZE-1:0] AccMax = {1'b0, {(ACC_SIZE-1){1'b1}}};

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e                     state_q, state_d;
  logic signed [ACC_SIZE-1:0] acc_q, acc_d;
  logic [CntW-1:0]            chunk_q, chunk_d;
  logic [IDX_SIZE-1:0]        neuron_q, neuron_d;
  logic signed [ACC_SIZE-1:0] max_q, max_d;
  logic [IDX_SIZE-1:0]        max_idx_q, max_idx_d;
  logic [IDX_SIZE-1:0]        class_q, class_d;
`ifdef NEURON_ARGMAX_SCORE_OUT_EN
  logic [ACC_SIZE-1:0]        score_q, score_d;
`endif

  logic signed [ACC_SIZE:0]   sum_wide;
  logic signed [ACC_SIZE-1:0] sum_sat;
  logic                       last_chunk, last_neuron, better;

  // One guard bit is enough to detect overflow of a single add.
  always_comb begin
    sum_wide = {acc_q[ACC_SIZE-1], acc_q}
             + {{(ACC_SIZE+1-VAL_SIZE){bus.value[VAL_SIZE-1]}}, bus.value};
    if (sum_wide[ACC_SIZE] != sum_wide[ACC_SIZE-1]) begin
      sum_sat = sum_wide[ACC_SIZE] ? AccMin : AccMax;
    end else begin
      sum_sat = sum_wide[ACC_SIZE-1:0];
    end
  end

  assign last_chunk  = (chunk_q == CntW'(CHUNKS - 1));
  assign last_neuron = (neuron_q == IDX_SIZE'(NEURONS - 1));
  assign better      = (sum_sat > max_q);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    chunk_d   = chunk_q;
    neuron_d  = neuron_q;
    max_d     = max_q;
    max_idx_d = max_idx_q;
    class_d   = class_q;
`ifdef NEURON_ARGMAX_SCORE_OUT_EN
    score_d   = score_q;
`endif
    // start restarts from any state; DONE still pulses class_valid this cycle.
    if (bus.start) begin
      state_d   = StAccum;
      acc_d     = '0;
      chunk_d   = '0;
      neuron_d  = '0;
      max_d     = AccMin;
      max_idx_d = '0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAccum: begin
          if (bus.value_valid) begin
            if (last_chunk) begin
              acc_d    = '0;
              chunk_d  = '0;
              neuron_d = neuron_q + 1'b1;
              if (better) begin
                max_d     = sum_sat;
                max_idx_d = neuron_q;
              end
              if (last_neuron) begin
                state_d  = StDone;
                neuron_d = '0;
                class_d  = better ? neuron_q : max_idx_q;
`ifdef NEURON_ARGMAX_SCORE_OUT_EN
                score_d  = better ? sum_sat : max_q;
`endif
              end
            end else begin
              acc_d   = sum_sat;
              chunk_d = chunk_q + 1'b1;
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      chunk_q   <= '0;
      neuron_q  <= '0;
      max_q     <= '0;
      max_idx_q <= '0;
      class_q   <= '0;
`ifdef NEURON_ARGMAX_SCORE_OUT_EN
      score_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      chunk_q   <= chunk_d;
      neuron_q  <= neuron_d;
      max_q     <= max_d;
      max_idx_q <= max_idx_d;
      class_q   <= class_d;
`ifdef NEURON_ARGMAX_SCORE_OUT_EN
      score_q   <= score_d;
`endif
    end
  end

  assign bus.busy        = (state_q == StAccum);
  assign bus.class_valid = (state_q == StDone);
  assign bus.class_out   = class_q;
`ifdef NEURON_ARGMAX_SCORE_OUT_EN
  assign bus.max_score   = score_q;
`endif

endmodule

// File: tb/tb_neuron_argmax.sv
// Directed bench: drives a 28-bit and a 26-bit accumulator instance with the same partials
// and checks class results, pulse timing, abort, restart-in-DONE and async reset.
module tb_neuron_argmax;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [25:0] value;
  logic        value_valid;
  logic [25:0] vals [40];
  int          n_cmp = 0;
  int          n_err = 0;
  int          early;
  int          cv_count = 0;
  int          cv_snap;

  always #5 clk = ~clk;

`ifdef NEURON_ARGMAX_SCORE_OUT_EN
  neuron_argmax_if #(.VAL_SIZE(26), .ACC_SIZE(28), .IDX_SIZE(4)) bus28 ();
  neuron_argmax_if #(.VAL_SIZE(26), .ACC_SIZE(26), .IDX_SIZE(4)) bus26 ();
`else
  neuron_argmax_if #(.VAL_SIZE(26), .IDX_SIZE(4)) bus28 ();
  neuron_argmax_if #(.VAL_SIZE(26), .IDX_SIZE(4)) bus26 ();
`endif

  assign bus28.start       = start;
  assign bus28.value       = value;
  assign bus28.value_valid = value_valid;
  assign bus26.start       = start;
  assign bus26.value       = value;
  assign bus26.value_valid = value_valid;

  neuron_argmax #(.NEURONS(10), .CHUNKS(4), .VAL_SIZE(26), .ACC_SIZE(28), .IDX_SIZE(4)) u_dut (
    .clk         (clk),
    .GlobalReset (rst_n),
    .bus         (bus28)
  );

  neuron_argmax #(.NEURONS(10), .CHUNKS(4), .VAL_SIZE(26), .ACC_SIZE(26), .IDX_SIZE(4)) u_sat (
    .clk         (clk),
    .GlobalReset (rst_n),
    .bus         (bus26)
  );

  always @(posedge clk) if (bus28.class_valid) cv_count <= cv_count + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_n(input int n, input int a, input int b, input int c, input int d);
    vals[4*n]   = 26'(a);
    vals[4*n+1] = 26'(b);
    vals[4*n+2] = 26'(c);
    vals[4*n+3] = 26'(d);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Feeds vals[0..cnt-1] back to back; counts any class_valid seen before the last accept.
  task automatic feed(input int cnt);
    early = 0;
    for (int i = 0; i < cnt; i++) begin
      value       = vals[i];
      value_valid = 1'b1;
      if (bus28.class_valid || bus26.class_valid) early++;
      step();
    end
    value_valid = 1'b0;
  endtask

  // Called one step after the final partial: this is the DONE cycle.
  task automatic check_done(input string tag, input int exp_cls);
    chk({tag, "_no_early_cv"}, 32'(early), 32'd0);
    chk({tag, "_cv28"}, 32'(bus28.class_valid), 32'd1);
    chk({tag, "_cls28"}, 32'(bus28.class_out), 32'(exp_cls));
    chk({tag, "_busy28"}, 32'(bus28.busy), 32'd0);
    chk({tag, "_cv26"}, 32'(bus26.class_valid), 32'd1);
    chk({tag, "_cls26"}, 32'(bus26.class_out), 32'(exp_cls));
  endtask

  task automatic check_after(input string tag, input int exp_cls);
    chk({tag, "_cv_one_cycle"}, 32'(bus28.class_valid), 32'd0);
    chk({tag, "_cls_held"}, 32'(bus28.class_out), 32'(exp_cls));
    chk({tag, "_idle"}, 32'(bus28.busy), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    value       = '0;
    value_valid = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(bus28.busy), 32'd0);
    chk("rst_cls", 32'(bus28.class_out), 32'd0);
    chk("rst_cv", 32'(bus28.class_valid), 32'd0);
    rst_n = 1'b1;
    step();

    // Image 1: neuron n = 4n, neuron 7 = 100
    for (int n = 0; n < 10; n++) set_n(n, n, n, n, n);
    set_n(7, 100, 0, 0, 0);
    do_start();
    chk("t1_busy", 32'(bus28.busy), 32'd1);
    feed(40);
    check_done("t1", 7);
    step();
    check_after("t1", 7);

    // Image 2: tie at 50 between neurons 2 and 5
    for (int n = 0; n < 10; n++) set_n(n, 10, 0, 0, 0);
    set_n(2, 20, 10, 10, 10);
    set_n(5, 50, 0, 0, 0);
    do_start();
    feed(40);
    check_done("t2", 2);
    step();
    check_after("t2", 2);

    // Image 3: all negative, neuron 4 = -3
    for (int n = 0; n < 10; n++) set_n(n, -(n + 1) * 8, 0, 0, 0);
    set_n(4, -3, 0, 0, 0);
    do_start();
    feed(40);
    check_done("t3", 4);
    step();
    check_after("t3", 4);

    // Image 4: large scores; 26-bit copy saturates both neurons 0 and 1 to 2^25-1 (tie)
    for (int n = 0; n < 10; n++) set_n(n, 0, 0, 0, 0);
    set_n(0, 33554431, 33554431, 33554431, 33554431);
    set_n(1, 33554431, 1, 0, 0);
    do_start();
    feed(40);
    check_done("t4", 0);
`ifdef NEURON_ARGMAX_SCORE_OUT_EN
    chk("t4_score28", 32'(bus28.max_score), 32'd134217724);
    chk("t4_score26", 32'(bus26.max_score), 32'd33554431);
`endif
    step();
    check_after("t4", 0);

    // Abort after 17 partials, then full image with winner 3
    cv_snap = cv_count;
    do_start();
    feed(17);
    chk("t5_busy_mid", 32'(bus28.busy), 32'd1);
    for (int n = 0; n < 10; n++) set_n(n, 1, 1, 1, 1);
    set_n(3, 20, 0, 0, 0);
    do_start();
    feed(40);
    check_done("t5", 3);
    // start during DONE: pulse stays, block goes straight to ACCUM
    start = 1'b1;
    chk("t5_cv_with_start", 32'(bus28.class_valid), 32'd1);
    step();
    start = 1'b0;
    chk("t5_one_pulse", 32'(cv_count - cv_snap), 32'd1);
    chk("t7_busy_after_done_start", 32'(bus28.busy), 32'd1);
    chk("t7_cv_low", 32'(bus28.class_valid), 32'd0);
    chk("t7_cls_held", 32'(bus28.class_out), 32'd3);
    set_n(3, 1, 1, 1, 1);
    set_n(9, 5, 5, 5, 5);
    feed(40);
    check_done("t7", 9);
    step();
    check_after("t7", 9);

    // Async reset mid-image
    do_start();
    feed(25);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(bus28.busy), 32'd0);
    chk("t6_rst_cls", 32'(bus28.class_out), 32'd0);
    step();
    rst_n = 1'b1;
    value = 26'd1000;
    value_valid = 1'b1;
    step();
    step();
    step();
    chk("t6_idle_ignores_valid", 32'(bus28.busy), 32'd0);
    chk("t6_idle_no_cv", 32'(bus28.class_valid), 32'd0);
    value_valid = 1'b0;
    set_n(9, 1, 1, 1, 1);
    set_n(6, 7, 7, 7, 7);
    do_start();
    feed(40);
    check_done("t6", 6);
    step();
    check_after("t6", 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
